alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencing and sharing controller for the single 32-bit ALU datapath. Accepts operations from two requesters over valid/ready, selects one per transaction, drives the ALU control and operands from registered copies, and holds the ALU inputs stable for a multi-cycle window on multiply. It then returns the captured result on a single response channel tagged with the requester ID. It sits between the issue logic (two clients, e.g. main pipe and address/aux unit) and the combinational ALU instance.

## Interface
- MUL_CYCLES, 4: cycles the ALU inputs are held for ALUCtl=3'b101 (mul); legal range 1..15.
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- req_valid_i  input  2  bit i: requester i has an operation.
- req_ready_o  output  2  bit i: requester i accepted this cycle (one-hot or zero).
- req0_ctl_i, req1_ctl_i  input  3  ALU opcode: 000 and, 001 xor, 010 sll, 011 add, 100 sub, 101 mul, 110 sra, 111 illegal.
- req0_a_i, req1_a_i  input  32  operand a.
- req0_b_i, req1_b_i  input  32  operand b.
- alu_ctl_o  output  3  to ALU ALUCtl, registered.
- alu_a_o, alu_b_o  output  32  to ALU a/b, registered.
- alu_out_i  input  32  from ALU out.
- rsp_valid_o  output  1  result available.
- rsp_ready_i  input  1  consumer takes result.
- rsp_data_o  output  32  result.
- rsp_id_o  output  1  requester index of this result.
- rsp_err_o  output  1  opcode was 111.
- busy_o  output  1  state != IDLE.

## Operation
- States: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if any req_valid_i, arbitrate; req_ready_o[g]=1 for winner g (combinational from state and req_valid_i). On accept, latch winner's ctl/a/b into alu_*_o, latch g, load cnt = (ctl==101) ? MUL_CYCLES-1 : 0, go EXEC.
- EXEC: ALU inputs held constant. If cnt!=0, decrement and stay. If cnt==0: capture rsp_data_o = alu_out_i (or 0 if ctl==111), rsp_err_o = (ctl==111), rsp_id_o = g, go RESP.
- RESP: rsp_valid_o=1; data/id/err held stable. On rsp_valid_o & rsp_ready_i go IDLE. No acceptance in RESP or EXEC (req_ready_o=0).
- Arbitration (see Configuration): only updates priority state on acceptance; a requester's valid may drop before acceptance without effect.
- Illegal opcode 111: still one EXEC cycle; ALU output ignored; data 0, err 1.
- Shift/width rules belong to the ALU; the block passes a, b unmodified and never truncates the result.
- Reset (any state, including mid-mul or RESP): next cycle IDLE, rsp_valid_o=0, transaction discarded, no response issued.

## Timing
- Reset values: req_ready_o=0 while rst_i high, rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rsp_err_o=0, alu_ctl_o=0, alu_a_o=0, alu_b_o=0, busy_o=0.
- Accept at edge N (IDLE, valid&ready): alu_*_o valid from N+1.
- Non-mul: EXEC is one cycle; rsp_valid_o high from cycle N+2.
- Mul: EXEC lasts MUL_CYCLES cycles; rsp_valid_o high from cycle N+1+MUL_CYCLES.
- Response handshake at edge M: IDLE at M+1; next accept earliest at M+1. Minimum 3 cycles per non-mul op.
- rsp_valid_o, once high, stays high until handshake or reset.

## Configuration
- ALU_ARB_RR_EN defined: round-robin; last-grant register resets to 1 (req0 wins the first conflict); on conflict, the requester not last granted wins.
- Not defined: fixed priority; req0 always wins when both valid; last-grant register not implemented.

## Test plan
- req0 add a=5 b=7, accept at N -> rsp_valid_o at N+2, data 12, id 0, err 0.
- MUL_CYCLES=4, req1 mul a=6 b=7 -> alu_*_o stable 4 cycles, rsp at N+5, data 42, id 1.
- Both valid continuously, sub 10-3 on req0, sll 1<<4 on req1, RR_EN on -> order id0 (7), id1 (16), id0, id1; RR_EN off -> only id0 served while req0 valid.
- rsp_ready_i low for 5 cycles after result xor 0xF0^0xFF -> rsp_data_o=0x0F held, rsp_valid_o high, req_ready_o=0 throughout; release -> IDLE next cycle.
- req0 ctl=111 -> rsp data 0, err 1 at N+2.
- rst_i pulsed on the 2nd EXEC cycle of a mul -> next cycle IDLE, busy_o=0, rsp_valid_o never asserted for that op, all outputs at reset values.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two requesters.
// Picks one operation per transaction and drives the ALU from registered
// operands. Operands are held for MUL_CYCLES cycles on mul. The captured result
// is returned on a single response channel, tagged with the requester id.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration;
// otherwise req0 has fixed priority.
module alu_arbiter #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [2:0]        req0_ctl_i,
  input  logic [2:0]        req1_ctl_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [DATA_W-1:0] req1_b_i,
  output logic [2:0]        alu_ctl_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_out_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_id_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              own_id;
  logic              win;
  logic              accept;
  logic [2:0]        sel_ctl;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  logic [2:0]        alu_ctl_p0;
  logic [DATA_W-1:0] alu_a_p0;
  logic [DATA_W-1:0] alu_b_p0;
  logic [DATA_W-1:0] rsp_data_p1;
  logic              rsp_id_p1;
  logic              rsp_err_p1;
  logic              vld_p1;

`ifdef ALU_ARB_RR_EN
  logic last_gnt;

  // Round-robin: on a conflict the requester not granted last time wins.
  always_comb begin
    win = 1'b0;
    if (req_valid_i == 2'b11) win = ~last_gnt;
    else                      win = req_valid_i[1];
  end

  // Last-grant register; resets to 1 so req0 wins the first conflict.
  always_ff @(posedge clk_i) begin
    if (rst_i)       last_gnt <= 1'b1;
    else if (accept) last_gnt <= win;
  end
`else
  // Fixed priority: req0 wins whenever it is valid.
  always_comb begin
    win = 1'b0;
    if (!req_valid_i[0]) win = 1'b1;
  end
`endif

  // Operand mux for the winning requester.
  always_comb begin
    sel_ctl = win ? req1_ctl_i : req0_ctl_i;
    sel_a   = win ? req1_a_i   : req0_a_i;
    sel_b   = win ? req1_b_i   : req0_b_i;
  end

  // Next-state and handshake decode; ready only from IDLE, never in reset.
  always_comb begin
    state_nxt   = state;
    req_ready_o = 2'b00;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid_i && !rst_i) begin
          accept      = 1'b1;
          req_ready_o = win ? 2'b10 : 2'b01;
          state_nxt   = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control: state, hold counter and owner of the current transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      own_id <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= (sel_ctl == OP_MUL) ? 4'(MUL_CYCLES - 1) : 4'd0;
        own_id <= win;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Stage p0: operand capture on accept; held stable through EXEC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alu_ctl_p0 <= 3'b000;
      alu_a_p0   <= '0;
      alu_b_p0   <= '0;
    end else if (accept) begin
      alu_ctl_p0 <= sel_ctl;
      alu_a_p0   <= sel_a;
      alu_b_p0   <= sel_b;
    end
  end

  // Stage p1: result capture at the last EXEC cycle; illegal op yields 0/err.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_data_p1 <= '0;
      rsp_id_p1   <= 1'b0;
      rsp_err_p1  <= 1'b0;
    end else if (state == EXEC && cnt == 4'd0) begin
      rsp_data_p1 <= (alu_ctl_p0 == OP_ILL) ? '0 : alu_out_i;
      rsp_err_p1  <= (alu_ctl_p0 == OP_ILL);
      rsp_id_p1   <= own_id;
    end
  end

  assign vld_p1      = (state == RESP);
  assign alu_ctl_o   = alu_ctl_p0;
  assign alu_a_o     = alu_a_p0;
  assign alu_b_o     = alu_b_p0;
  assign rsp_valid_o = vld_p1;
  assign rsp_data_o  = rsp_data_p1;
  assign rsp_id_o    = rsp_id_p1;
  assign rsp_err_o   = rsp_err_p1;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU.
// Expected responses are queued on acceptance and compared on the response
// handshake; directed tests check latency, hold, arbitration order and reset.
module tb_alu_arbiter;
  localparam int MUL_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [2:0]  req0_ctl_i, req1_ctl_i;
  logic [31:0] req0_a_i, req1_a_i, req0_b_i, req1_b_i;
  logic [2:0]  alu_ctl_o;
  logic [31:0] alu_a_o, alu_b_o, alu_out_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_id_o, rsp_err_o, busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  logic seen_ids[$];
  rsp_t mon_e;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req0_ctl_i(req0_ctl_i), .req1_ctl_i(req1_ctl_i),
    .req0_a_i(req0_a_i), .req1_a_i(req1_a_i),
    .req0_b_i(req0_b_i), .req1_b_i(req1_b_i),
    .alu_ctl_o(alu_ctl_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_out_i(alu_out_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o)
  );

  // Behavioural ALU; the illegal opcode returns garbage that must be ignored.
  function automatic logic [31:0] alu_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a ^ b;
      3'b010:  return a << b[4:0];
      3'b011:  return a + b;
      3'b100:  return a - b;
      3'b101:  return a * b;
      3'b110:  return 32'($signed(a) >>> b[4:0]);
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign alu_out_i = alu_fn(alu_ctl_o, alu_a_o, alu_b_o);

  function automatic rsp_t make_exp(input logic id, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    r.id   = id;
    r.err  = (c == 3'b111);
    r.data = (c == 3'b111) ? 32'd0 : alu_fn(c, a, b);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (req_ready_o[0] && req_valid_i[0])
        exp_q.push_back(make_exp(1'b0, req0_ctl_i, req0_a_i, req0_b_i));
      else if (req_ready_o[1] && req_valid_i[1])
        exp_q.push_back(make_exp(1'b1, req1_ctl_i, req1_a_i, req1_b_i));
      if (rsp_valid_o && rsp_ready_i) begin
        seen_ids.push_back(rsp_id_o);
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_data", rsp_data_o, mon_e.data);
          chk("sb_id", {31'd0, rsp_id_o}, {31'd0, mon_e.id});
          chk("sb_err", {31'd0, rsp_err_o}, {31'd0, mon_e.err});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request from an idle DUT; returns just after the accept edge.
  task automatic send(input logic id, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    if (!id) begin
      req0_ctl_i = c; req0_a_i = a; req0_b_i = b; req_valid_i = 2'b01;
    end else begin
      req1_ctl_i = c; req1_a_i = a; req1_b_i = b; req_valid_i = 2'b10;
    end
    #1;
    chk("accept_ready", {30'd0, req_ready_o}, id ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 2'b00;
  endtask

  // Wait for rsp_valid_o, checking ALU inputs stay stable; lat counts cycles
  // after the first EXEC cycle.
  task automatic wait_rsp(input int lat, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    while (!rsp_valid_o && k < 40) begin
      chk("hold_ctl", {29'd0, alu_ctl_o}, {29'd0, c});
      chk("hold_a", alu_a_o, a);
      chk("hold_b", alu_b_o, b);
      tick();
      k++;
    end
    chk("rsp_latency", k, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; rsp_ready_i = 1'b1; req_valid_i = 2'b01;
    req0_ctl_i = 3'd0; req1_ctl_i = 3'd0;
    req0_a_i = '0; req0_b_i = '0; req1_a_i = '0; req1_b_i = '0;
    repeat (3) tick();
    chk("rst_ready", {30'd0, req_ready_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_alu_ctl", {29'd0, alu_ctl_o}, 32'd0);
    chk("rst_rsp_data", rsp_data_o, 32'd0);
    req_valid_i = 2'b00;
    rst_i = 1'b0;
    tick();

    // add 5+7 from req0
    send(1'b0, 3'b011, 32'd5, 32'd7);
    wait_rsp(1, 3'b011, 32'd5, 32'd7);
    chk("add_data", rsp_data_o, 32'd12);
    chk("add_id", {31'd0, rsp_id_o}, 32'd0);
    chk("add_err", {31'd0, rsp_err_o}, 32'd0);
    tick();
    chk("add_idle", {31'd0, busy_o}, 32'd0);

    // mul 6*7 from req1, operands held MUL_CYCLES cycles
    send(1'b1, 3'b101, 32'd6, 32'd7);
    wait_rsp(MUL_CYCLES, 3'b101, 32'd6, 32'd7);
    chk("mul_data", rsp_data_o, 32'd42);
    chk("mul_id", {31'd0, rsp_id_o}, 32'd1);
    tick();
    chk("mul_idle", {31'd0, busy_o}, 32'd0);

    // both requesters valid continuously
    begin
      int k;
      seen_ids.delete();
      req0_ctl_i = 3'b100; req0_a_i = 32'd10; req0_b_i = 32'd3;
      req1_ctl_i = 3'b010; req1_a_i = 32'd1;  req1_b_i = 32'd4;
      req_valid_i = 2'b11;
      #1;
      chk("conflict_first", {30'd0, req_ready_o}, 32'd1);
      k = 0;
      while (seen_ids.size() < 4 && k < 100) begin
        tick();
        k++;
      end
      req_valid_i = 2'b00;
      chk("conflict_done", {31'd0, (k < 100)}, 32'd1);
      k = 0;
      while (busy_o && k < 20) begin
        tick();
        k++;
      end
      for (int i = 0; i < 4; i++) begin
        if (i < seen_ids.size()) begin
`ifdef ALU_ARB_RR_EN
          chk("conflict_order", {31'd0, seen_ids[i]}, 32'(i % 2));
`else
          chk("conflict_order", {31'd0, seen_ids[i]}, 32'd0);
`endif
        end
      end
    end

    // backpressure: xor 0xF0^0xFF held while rsp_ready_i low
    rsp_ready_i = 1'b0;
    send(1'b0, 3'b001, 32'hF0, 32'hFF);
    wait_rsp(1, 3'b001, 32'hF0, 32'hFF);
    req1_ctl_i = 3'b011; req1_a_i = 32'd1; req1_b_i = 32'd1;
    req_valid_i = 2'b10;
    repeat (5) begin
      tick();
      chk("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("bp_data", rsp_data_o, 32'h0F);
      chk("bp_ready", {30'd0, req_ready_o}, 32'd0);
    end
    req_valid_i = 2'b00;
    rsp_ready_i = 1'b1;
    tick();
    chk("bp_idle", {31'd0, busy_o}, 32'd0);
    chk("bp_valid_drop", {31'd0, rsp_valid_o}, 32'd0);

    // illegal opcode
    send(1'b0, 3'b111, 32'd123, 32'd456);
    wait_rsp(1, 3'b111, 32'd123, 32'd456);
    chk("ill_data", rsp_data_o, 32'd0);
    chk("ill_err", {31'd0, rsp_err_o}, 32'd1);
    tick();

    // reset in the second EXEC cycle of a mul
    send(1'b1, 3'b101, 32'd3, 32'd3);
    tick();
    chk("rstmul_busy_before", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rstmul_busy", {31'd0, busy_o}, 32'd0);
    chk("rstmul_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rstmul_err", {31'd0, rsp_err_o}, 32'd0);
    chk("rstmul_id", {31'd0, rsp_id_o}, 32'd0);
    chk("rstmul_data", rsp_data_o, 32'd0);
    chk("rstmul_ctl", {29'd0, alu_ctl_o}, 32'd0);
    chk("rstmul_a", alu_a_o, 32'd0);
    chk("rstmul_b", alu_b_o, 32'd0);
    repeat (8) begin
      tick();
      chk("rstmul_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    end

    // sra after reset recovery
    send(1'b1, 3'b110, 32'h80000000, 32'd4);
    wait_rsp(1, 3'b110, 32'h80000000, 32'd4);
    chk("sra_data", rsp_data_o, 32'hF8000000);
    tick();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
